// File: rtl/apply_iteration_end.sv
// Per-core output register stage of the BFS accelerator pipeline.
// Each lane registers its active-vertex fields and its iteration-end report.
// A lane's end flag is raised only when every core reports end in the same cycle.
// Each lane has its own asynchronous active-low reset bit.

module apply_iteration_end_lane #(
    parameter int V_ID_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [V_ID_WIDTH-1:0] front_active_v_id,
    input  logic                  front_active_v_updated,
    input  logic                  front_active_v_pull_first_flag,
    input  logic                  front_active_v_valid,
    input  logic                  front_iteration_end_valid,
    input  logic                  all_end,
    output logic [V_ID_WIDTH-1:0] active_v_id,
    output logic                  active_v_updated,
    output logic                  active_v_pull_first_flag,
    output logic                  active_v_valid,
    output logic                  iteration_end,
    output logic                  iteration_end_valid
);

    typedef struct packed {
        logic [V_ID_WIDTH-1:0] id;
        logic                  updated;
        logic                  pull_first;
        logic                  valid;
    } vtx_t;

    typedef struct packed {
        logic done;
        logic valid;
    } end_t;

    vtx_t vtx_d, vtx_q;
    end_t end_d, end_q;

    assign vtx_d = '{id:         front_active_v_id,
                     updated:    front_active_v_updated,
                     pull_first: front_active_v_pull_first_flag,
                     valid:      front_active_v_valid};

    // The global end is only forwarded on lanes that qualified their own report.
    assign end_d = '{done:  front_iteration_end_valid & all_end,
                     valid: front_iteration_end_valid};

    // Vertex fields are captured every cycle regardless of valid; there is no stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vtx_q <= '0;
        else        vtx_q <= vtx_d;
    end

    // End report is registered alongside, with no memory of earlier cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) end_q <= '0;
        else        end_q <= end_d;
    end

    assign active_v_id              = vtx_q.id;
    assign active_v_updated         = vtx_q.updated;
    assign active_v_pull_first_flag = vtx_q.pull_first;
    assign active_v_valid           = vtx_q.valid;
    assign iteration_end            = end_q.done;
    assign iteration_end_valid      = end_q.valid;

endmodule

module apply_iteration_end #(
    parameter int V_ID_WIDTH = 32,
    parameter int CORE_NUM   = 16
) (
    input  logic                           clk,
    input  logic [CORE_NUM-1:0]            rst,
    input  logic [CORE_NUM*V_ID_WIDTH-1:0] front_active_v_id,
    input  logic [CORE_NUM-1:0]            front_active_v_updated,
    input  logic [CORE_NUM-1:0]            front_active_v_pull_first_flag,
    input  logic [CORE_NUM-1:0]            front_active_v_valid,
    input  logic [CORE_NUM-1:0]            front_iteration_end,
    input  logic [CORE_NUM-1:0]            front_iteration_end_valid,
    output logic [CORE_NUM*V_ID_WIDTH-1:0] active_v_id,
    output logic [CORE_NUM-1:0]            active_v_updated,
    output logic [CORE_NUM-1:0]            active_v_pull_first_flag,
    output logic [CORE_NUM-1:0]            active_v_valid,
    output logic [CORE_NUM-1:0]            iteration_end,
    output logic [CORE_NUM-1:0]            iteration_end_valid
);

    logic all_end;

    // Global end depends only on the input vectors; a lane held in reset
    // does not mask it.
    assign all_end = (&front_iteration_end) & (&front_iteration_end_valid);

    for (genvar i = 0; i < CORE_NUM; i++) begin : g_lane
        apply_iteration_end_lane #(
            .V_ID_WIDTH (V_ID_WIDTH)
        ) u_lane (
            .clk                            (clk),
            .rst_n                          (rst[i]),
            .front_active_v_id              (front_active_v_id[i*V_ID_WIDTH +: V_ID_WIDTH]),
            .front_active_v_updated         (front_active_v_updated[i]),
            .front_active_v_pull_first_flag (front_active_v_pull_first_flag[i]),
            .front_active_v_valid           (front_active_v_valid[i]),
            .front_iteration_end_valid      (front_iteration_end_valid[i]),
            .all_end                        (all_end),
            .active_v_id                    (active_v_id[i*V_ID_WIDTH +: V_ID_WIDTH]),
            .active_v_updated               (active_v_updated[i]),
            .active_v_pull_first_flag       (active_v_pull_first_flag[i]),
            .active_v_valid                 (active_v_valid[i]),
            .iteration_end                  (iteration_end[i]),
            .iteration_end_valid            (iteration_end_valid[i])
        );
    end

endmodule

// File: tb/tb_apply_iteration_end.sv
// Directed plus randomized bench for apply_iteration_end with a lane-array
// reference model.

module tb_apply_iteration_end;

    localparam int W = 32;
    localparam int N = 16;

    logic           clk = 1'b0;
    logic [N-1:0]   rst;
    logic [N*W-1:0] f_id;
    logic [N-1:0]   f_upd, f_pf, f_vld, f_end, f_endv;
    logic [N*W-1:0] active_v_id;
    logic [N-1:0]   active_v_updated, active_v_pull_first_flag, active_v_valid;
    logic [N-1:0]   iteration_end, iteration_end_valid;

    // Reference model: what each lane should be showing right now.
    logic [W-1:0]   m_id [N];
    logic [N-1:0]   m_upd, m_pf, m_vld, m_end, m_endv;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    apply_iteration_end #(.V_ID_WIDTH(W), .CORE_NUM(N)) dut (
        .clk                            (clk),
        .rst                            (rst),
        .front_active_v_id              (f_id),
        .front_active_v_updated         (f_upd),
        .front_active_v_pull_first_flag (f_pf),
        .front_active_v_valid           (f_vld),
        .front_iteration_end            (f_end),
        .front_iteration_end_valid      (f_endv),
        .active_v_id                    (active_v_id),
        .active_v_updated               (active_v_updated),
        .active_v_pull_first_flag       (active_v_pull_first_flag),
        .active_v_valid                 (active_v_valid),
        .iteration_end                  (iteration_end),
        .iteration_end_valid            (iteration_end_valid)
    );

    task automatic cmp(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear(input int lane);
        m_id[lane]   = '0;
        m_upd[lane]  = 1'b0;
        m_pf[lane]   = 1'b0;
        m_vld[lane]  = 1'b0;
        m_end[lane]  = 1'b0;
        m_endv[lane] = 1'b0;
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < N; i++)
            cmp($sformatf("%s.id[%0d]", tag, i), active_v_id[i*W +: W], m_id[i]);
        cmp({tag, ".updated"},    {16'h0, active_v_updated},         {16'h0, m_upd});
        cmp({tag, ".pull_first"}, {16'h0, active_v_pull_first_flag}, {16'h0, m_pf});
        cmp({tag, ".valid"},      {16'h0, active_v_valid},           {16'h0, m_vld});
        cmp({tag, ".end"},        {16'h0, iteration_end},            {16'h0, m_end});
        cmp({tag, ".end_valid"},  {16'h0, iteration_end_valid},      {16'h0, m_endv});
    endtask

    // Predict the next register contents from the inputs presented this cycle,
    // advance one clock, then compare.
    task automatic tick(input string tag);
        int  reporting;
        bit  every_core_done;
        reporting = 0;
        for (int i = 0; i < N; i++)
            if (f_end[i] && f_endv[i]) reporting++;
        every_core_done = (reporting == N);
        for (int i = 0; i < N; i++) begin
            if (!rst[i]) model_clear(i);
            else begin
                m_id[i]   = f_id[i*W +: W];
                m_upd[i]  = f_upd[i];
                m_pf[i]   = f_pf[i];
                m_vld[i]  = f_vld[i];
                m_endv[i] = f_endv[i];
                m_end[i]  = f_endv[i] && every_core_done;
            end
        end
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic randomize_inputs();
        for (int i = 0; i < N; i++) f_id[i*W +: W] = $urandom;
        f_upd  = N'($urandom);
        f_pf   = N'($urandom);
        f_vld  = N'($urandom);
        f_end  = ($urandom_range(0, 2) == 0) ? '1 : N'($urandom);
        f_endv = ($urandom_range(0, 2) == 0) ? '1 : N'($urandom);
    endtask

    initial begin
        rst = '0; f_id = '0; f_upd = '0; f_pf = '0; f_vld = '0; f_end = '0; f_endv = '0;
        for (int i = 0; i < N; i++) model_clear(i);

        // Reset state while held
        #12;
        check_all("reset_held");

        // Release and clock once with zero inputs
        @(negedge clk);
        rst = '1;
        tick("post_reset");

        // Lane i carries id=i with all flags set
        for (int i = 0; i < N; i++) f_id[i*W +: W] = W'(i);
        f_upd = '1; f_pf = '1; f_vld = '1;
        tick("lane_id");
        cmp("lane_id.direct5", active_v_id[5*W +: W], 32'd5);

        // Even lanes only report end
        f_endv = '1; f_end = 16'h5555;
        tick("even_end");
        cmp("even_end.direct", {16'h0, iteration_end}, 32'h0);

        // All but lane 0 report end
        f_end = 16'hFFFE;
        tick("all_but_0");
        cmp("all_but_0.direct_v", {16'h0, iteration_end_valid}, 32'h0000_FFFF);

        // Every lane reports end
        f_end = '1;
        tick("all_end");
        cmp("all_end.direct", {16'h0, iteration_end}, 32'h0000_FFFF);

        // Deassert: no stickiness
        f_end = '0; f_endv = '0;
        tick("end_drop");
        cmp("end_drop.direct", {16'h0, iteration_end}, 32'h0);

        // Async reset of lane 3 mid-cycle
        randomize_inputs();
        tick("pre_async");
        #3;
        rst[3] = 1'b0;
        #1;
        model_clear(3);
        check_all("async_rst3");
        cmp("async_rst3.direct", active_v_id[3*W +: W], 32'h0);

        // Lane 3 held in reset must not mask the global end
        f_end = '1; f_endv = '1;
        tick("rst3_all_end");
        @(negedge clk);
        rst[3] = 1'b1;
        tick("rst3_release");

        // Randomized traffic with occasional per-lane resets
        for (int c = 0; c < 300; c++) begin
            randomize_inputs();
            if ($urandom_range(0, 9) == 0) rst = ~(N'(1) << $urandom_range(0, N-1));
            else rst = '1;
            tick($sformatf("rand%0d", c));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/apply_iteration_end.md
Name: apply_iteration_end

Overview:
- Per-core output register stage of the BFS accelerator pipeline.
- Passes each core's active-vertex stream through with one cycle of latency.
- Converts per-core iteration-end reports into a global end. A core's iteration_end is asserted only when every core reports end in the same cycle.
- Sits between the per-core front pipeline and the downstream apply/scheduler logic.

Parameters:
- V_ID_WIDTH, 32, width of one vertex ID.
- CORE_NUM, 16, number of parallel cores (lanes).

Ports:
- clk  in  1  single clock; all registers update on the rising edge.
- rst  in  CORE_NUM  asynchronous active-low reset, one bit per lane; rst[i]=0 resets lane i's registers.
- front_active_v_id  in  CORE_NUM*V_ID_WIDTH  lane i occupies bits [i*V_ID_WIDTH +: V_ID_WIDTH].
- front_active_v_updated  in  CORE_NUM  per-lane updated flag.
- front_active_v_pull_first_flag  in  CORE_NUM  per-lane pull-first flag.
- front_active_v_valid  in  CORE_NUM  per-lane vertex valid.
- front_iteration_end  in  CORE_NUM  per-lane "this core finished the iteration".
- front_iteration_end_valid  in  CORE_NUM  per-lane qualifier for front_iteration_end.
- active_v_id  out  CORE_NUM*V_ID_WIDTH  registered vertex IDs, same lane packing as the input.
- active_v_updated  out  CORE_NUM  registered updated flag.
- active_v_pull_first_flag  out  CORE_NUM  registered pull-first flag.
- active_v_valid  out  CORE_NUM  registered valid.
- iteration_end  out  CORE_NUM  global-end flag, replicated per lane.
- iteration_end_valid  out  CORE_NUM  registered per-lane end valid.

Behaviour:
- Reset: while rst[i]=0, lane i's outputs are forced to 0 asynchronously: id, updated, pull_first_flag, valid, iteration_end, iteration_end_valid. Outputs stay 0 after rst[i] releases until the next clock edge with nonzero inputs.
- Latency is exactly one clock for every output; there is no combinational input-to-output path.
- Vertex path, per lane i, each rising edge:
  - active_v_id[i] <= front_active_v_id[i]
  - active_v_updated[i] <= front_active_v_updated[i]
  - active_v_pull_first_flag[i] <= front_active_v_pull_first_flag[i]
  - active_v_valid[i] <= front_active_v_valid[i]
  - Fields are captured unconditionally, independent of valid. No backpressure and no handshake; downstream must accept every cycle.
- End path:
  - all_end = (&front_iteration_end) & (&front_iteration_end_valid), evaluated combinationally over all CORE_NUM lanes in the same cycle.
  - iteration_end_valid[i] <= front_iteration_end_valid[i].
  - iteration_end[i] <= front_iteration_end_valid[i] & all_end.
  - Partial end (any lane with end=0 or valid=0): iteration_end=0 on every lane, while iteration_end_valid follows each lane's valid.
  - No stickiness or accumulation across cycles. Every lane must report end in the same cycle; reports are not remembered.
- Vertex and end paths are independent. A lane may present valid vertex data and end_valid in the same cycle; both are registered.
- Reset mid-operation: asserting rst[i] clears lane i immediately. Other lanes are unaffected, but a lane held in reset does not suppress all_end, which depends only on the input vectors.
- No state machine; the block is purely registered.

Test Plan:
- Reset with all inputs 0, release, one clock -> all outputs 0 on every lane.
- Lane i drives id=i, updated=1, pull_first=1, valid=1 -> one clock later active_v_id lane i == i and the updated, pull_first and valid bits are all 1.
- end_valid all 1, end=1 on even lanes only -> next cycle iteration_end=0 on all lanes, iteration_end_valid all 1.
- end_valid all 1, end=1 on every lane except lane 0 -> iteration_end all 0, iteration_end_valid all 1.
- end=1 and end_valid=1 on all lanes -> next cycle iteration_end all 1, iteration_end_valid all 1. Inputs deasserted the following cycle -> both outputs return to 0.
- Data valid, then rst[3] pulled low mid-cycle -> lane 3 outputs 0 immediately without waiting for a clock edge; other lanes keep their registered values.
